deserializer: RTL and testbench

- Receive-side counterpart of the team's LSB-first bit serializer: collects one serial bit per clock while the link's busy/valid line is high and rebuilds DATA_WIDTH-bit words.
- Each completed word is presented on a one-entry valid/ready output register.
- Reports aborted frames (busy dropped mid-word) and overruns (word completed while the output register is still full).
- Sits at the far end of a serial link, feeding a parallel consumer such as a FIFO or register file.

---
 rtl/deserializer.sv | 151 +++++++++++++++
 tb/tb_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel receiver with a one-entry valid/ready output register.
// Optional DESERIALIZER_STATS_EN adds o_word_cnt / o_drop_cnt statistics counters.
module deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_busy,
  input  logic                  i_sdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_err,
  output logic                  o_overrun
`ifdef DESERIALIZER_STATS_EN
  ,
  output logic [15:0]           o_word_cnt,
  output logic [15:0]           o_drop_cnt
`endif
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  // Handshake: o_data is transferred on a rising edge where o_valid && i_ready;
  // o_data is held stable while o_valid is high.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_err;
  logic                  r_overrun;
  logic                  w_complete;
  logic                  w_abort;
  logic                  w_load;
  logic                  w_overrun;
  logic [DATA_WIDTH-1:0] w_word;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    // The final bit bypasses the shift register so the word loads on the same edge.
    w_word       = {i_sdata, r_shift[DATA_WIDTH-2:0]};
    case (r_state)
      IDLE: begin
        if (i_busy) begin
          w_next_state = SHIFT;
          w_cnt_next   = CW'(1);
        end
      end
      SHIFT: begin
        if (i_busy) begin
          if (r_cnt == LAST) begin
            w_complete   = 1'b1;
            w_cnt_next   = '0;
            w_next_state = IDLE;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end else begin
          w_abort      = 1'b1;
          w_cnt_next   = '0;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_load    = w_complete && (!r_valid || i_ready);
  assign w_overrun = w_complete && r_valid && !i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter is always 0 in IDLE, so one indexed write covers both states.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (i_busy) begin
      r_shift[r_cnt] <= i_sdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_err     <= w_abort;
      r_overrun <= w_overrun;
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_err     = r_err;
  assign o_overrun = r_overrun;

`ifdef DESERIALIZER_STATS_EN
  logic [15:0] r_word_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_load) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_abort || w_overrun) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign o_word_cnt = r_word_cnt;
  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (DATA_WIDTH=8); inputs driven and
// outputs sampled on the falling edge. Define DESERIALIZER_STATS_EN to check the counters.
module tb_deserializer;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       sdata;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       overrun;
`ifdef DESERIALIZER_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  deserializer #(.DATA_WIDTH(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_busy    (busy),
    .i_sdata   (sdata),
    .o_data    (data),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_err     (err),
    .o_overrun (overrun)
`ifdef DESERIALIZER_STATS_EN
    ,
    .o_word_cnt(word_cnt),
    .o_drop_cnt(drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    busy  = 1'b1;
    sdata = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    busy  = 1'b0;
    sdata = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    busy  = 1'b0;
    sdata = 1'b0;
    ready = 1'b1;
    #2;
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single word 0xA5
    send_word(8'hA5);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_err", 32'(err), 32'h0);
    check("a5_overrun", 32'(overrun), 32'h0);
    idle(1);
    check("a5_consumed", 32'(valid), 32'h0);

    // Back-to-back 0x3C, 0xC3 with no gap
    send_word(8'h3C);
    check("b2b_first_valid", 32'(valid), 32'h1);
    check("b2b_first_data", 32'(data), 32'h3C);
    send_word(8'hC3);
    check("b2b_second_valid", 32'(valid), 32'h1);
    check("b2b_second_data", 32'(data), 32'hC3);
    check("b2b_err", 32'(err), 32'h0);
    idle(1);

    // Abort after 5 bits, then a clean 0x5A
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    idle(1);
    check("abort_err", 32'(err), 32'h1);
    check("abort_valid", 32'(valid), 32'h0);
    idle(1);
    check("abort_err_clear", 32'(err), 32'h0);
    send_word(8'h5A);
    check("after_abort_valid", 32'(valid), 32'h1);
    check("after_abort_data", 32'(data), 32'h5A);
    check("after_abort_err", 32'(err), 32'h0);
    idle(1);

    // Overrun: 0x22 arrives while 0x11 is still held
    ready = 1'b0;
    send_word(8'h11);
    check("ovr_first_valid", 32'(valid), 32'h1);
    check("ovr_first_data", 32'(data), 32'h11);
    check("ovr_first_flag", 32'(overrun), 32'h0);
    send_word(8'h22);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_valid_kept", 32'(valid), 32'h1);
    ready = 1'b1;
    idle(1);
    check("ovr_consumed", 32'(valid), 32'h0);
    check("ovr_flag_clear", 32'(overrun), 32'h0);
    check("ovr_data_held", 32'(data), 32'h11);
`ifdef DESERIALIZER_STATS_EN
    check("stats_words_a", 32'(word_cnt), 32'd5);
    check("stats_drops_a", 32'(drop_cnt), 32'd2);
`endif

    // Asynchronous reset mid-frame with a pending word
    ready = 1'b0;
    send_word(8'h7E);
    check("pend_valid", 32'(valid), 32'h1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2;
    rst  = 1'b1;
    busy = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_data", 32'(data), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
`ifdef DESERIALIZER_STATS_EN
    check("arst_word_cnt", 32'(word_cnt), 32'd0);
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    rst   = 1'b0;
    ready = 1'b1;
    send_word(8'h81);
    check("post_rst_valid", 32'(valid), 32'h1);
    check("post_rst_data", 32'(data), 32'h81);
    idle(1);

    // Event mix: 3 good words, 1 abort, 1 overrun
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_word(8'h01);
    idle(1);
    send_word(8'h02);
    check("mix_w2_data", 32'(data), 32'h02);
    idle(1);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    idle(1);
    check("mix_abort_err", 32'(err), 32'h1);
    idle(1);
    ready = 1'b0;
    send_word(8'h55);
    send_word(8'hAA);
    check("mix_overrun", 32'(overrun), 32'h1);
    check("mix_data", 32'(data), 32'h55);
`ifdef DESERIALIZER_STATS_EN
    check("mix_word_cnt", 32'(word_cnt), 32'd3);
    check("mix_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    ready = 1'b1;
    idle(2);
    check("mix_drained", 32'(valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
